// File: rtl/rv_muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide unit.
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} md_state_e;

    function automatic logic is_signed_a(md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(md_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/rv_muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem, quot[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    // rem < divisor on entry, so a borrow always shows up in the top bit
    always_comb begin
        if (!diff[XLEN]) begin
            rem_next  = diff[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = shifted[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/rv_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake on both sides.
module rv_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int N  = XLEN / MUL_STEP;
    localparam int CW = $clog2(XLEN) + 1;
    localparam int SW = XLEN + MUL_STEP;

    md_state_e         state;
    md_op_e            op;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mcand;
    // Multiply: {accumulator, multiplier}. Divide: {remainder, quotient/dividend}.
    logic [2*XLEN-1:0] prod;
    logic [CW-1:0]     cnt;

    md_op_e          fop;
    logic            neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign fop      = md_op_e'(funct3);
    assign neg_a    = is_signed_a(fop) && op_a[XLEN-1];
    assign neg_b    = is_signed_b(fop) && op_b[XLEN-1];
    assign mag_a    = neg_a ? -op_a : op_a;
    assign mag_b    = neg_b ? -op_b : op_b;
    assign div_zero = is_div(fop) && (op_b == '0);
    assign div_ovf  = is_div(fop) && is_signed_a(fop) && (&op_b) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}});
    assign special_res = is_rem(fop) ? (div_zero ? op_a : '0)
                                     : (div_zero ? '1   : op_a);

    logic [SW-1:0]     pp, sum;
    logic [2*XLEN-1:0] mul_next;

    assign pp       = SW'(mcand) * SW'(prod[MUL_STEP-1:0]);
    assign sum      = SW'(prod[2*XLEN-1:XLEN]) + pp;
    assign mul_next = {sum, prod[XLEN-1:MUL_STEP]};

    logic [XLEN-1:0] rem_next, quot_next;

    rv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem       (prod[2*XLEN-1:XLEN]),
        .quot      (prod[XLEN-1:0]),
        .divisor   (mcand),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot, rem, final_res;

    assign quot = prod[XLEN-1:0];
    assign rem  = prod[2*XLEN-1:XLEN];

    always_comb begin
        prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
        final_res = '0;
        case (op)
            OP_MUL:                        final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res = (sign_a ^ sign_b) ? -quot : quot;
            default:                       final_res = sign_a ? -rem : rem;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            op           <= OP_MUL;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            mcand        <= '0;
            prod         <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        op          <= fop;
                        sign_a      <= neg_a;
                        sign_b      <= neg_b;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        if (div_zero || div_ovf) begin
                            state  <= DONE;
                            result <= special_res;
                        end else if (is_div(fop)) begin
                            state <= DIV;
                            mcand <= mag_b;
                            prod  <= {{XLEN{1'b0}}, mag_a};
                        end else begin
                            state <= MUL;
                            mcand <= mag_a;
                            prod  <= {{XLEN{1'b0}}, mag_b};
                        end
                    end else begin
                        start_ready <= 1'b1;
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    if (cnt == CW'(N - 1)) state <= FIX;
                    else                   cnt   <= cnt + CW'(1);
                end
                DIV: begin
                    prod <= {rem_next, quot_next};
                    if (cnt == CW'(XLEN - 1)) state <= FIX;
                    else                      cnt   <= cnt + CW'(1);
                end
                FIX: begin
                    result       <= final_res;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    // Special cases arrive with the result loaded but valid still low,
                    // giving them one cycle of latency like the other paths' FIX stage.
                    if (!result_valid) begin
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit: arithmetic model + literal vectors, latency and handshake checks.
module tb_rv_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: XLEN=32, MUL_STEP=1
    logic        start_valid = 0, start_ready, result_valid, result_ready = 0, busy;
    logic [2:0]  funct3 = 0;
    logic [31:0] op_a = 0, op_b = 0, result;

    rv_muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .result_valid(result_valid),
        .result_ready(result_ready), .result(result), .busy(busy));

    // radix-16 multiply instance
    logic        s1_valid = 0, s1_ready, r1_valid, r1_ready = 0, busy1;
    logic [31:0] res1;
    rv_muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start_valid(s1_valid), .start_ready(s1_ready),
        .funct3(3'b000), .op_a(32'd7), .op_b(32'd9), .result_valid(r1_valid),
        .result_ready(r1_ready), .result(res1), .busy(busy1));

    // 16-bit instance
    logic        s2_valid = 0, s2_ready, r2_valid, r2_ready = 0, busy2;
    logic [15:0] res2;
    rv_muldiv_unit #(.XLEN(16), .MUL_STEP(1)) dut16 (
        .clk(clk), .rst(rst), .start_valid(s2_valid), .start_ready(s2_ready),
        .funct3(3'b000), .op_a(16'd7), .op_b(16'd9), .result_valid(r2_valid),
        .result_ready(r2_ready), .result(res2), .busy(busy2));

    int errors = 0;
    int checks = 0;
    logic        exp_valid = 0;
    logic [31:0] exp_res = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain integer arithmetic
    function automatic logic [31:0] model(input int xlen, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask = (longint'(1) << xlen) - 1;
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        longint sa = ua[xlen-1] ? ua - (longint'(1) << xlen) : ua;
        longint sb = ub[xlen-1] ? ub - (longint'(1) << xlen) : ub;
        longint r;
        logic ovf = (sa == -(longint'(1) << (xlen - 1))) && (sb == -1);
        case (f)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >> xlen;
            3'd2: r = (sa * ub) >> xlen;
            3'd3: r = (ua * ub) >> xlen;
            3'd4: r = (ub == 0) ? mask : ovf ? ua : sa / sb;
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? ua : ovf ? 0 : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    // whenever a result is presented it must match the model and stay stable
    always @(negedge clk) begin
        if (!rst && exp_valid && result_valid) chk("model_result", result, exp_res);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int lat_exp, input int hold);
        int n = 0;
        int lat = 0;
        while (!start_ready && n < 100) begin step(); n++; end
        chk("start_ready_before_op", {31'd0, start_ready}, 32'd1);
        funct3 = f; op_a = a; op_b = b; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        exp_res = model(32, f, a, b);
        exp_valid = 1'b1;
        while (!result_valid && lat < 200) begin step(); lat++; end
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("literal_result", result, lit);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) start_valid = 1'b1;
            step();
            start_valid = 1'b0;
            chk("hold_start_ready", {31'd0, start_ready}, 32'd0);
            chk("hold_valid", {31'd0, result_valid}, 32'd1);
            chk("hold_result", result, lit);
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        exp_valid = 1'b0;
        chk("post_hs_valid", {31'd0, result_valid}, 32'd0);
        chk("post_hs_busy", {31'd0, busy}, 32'd0);
        chk("post_hs_start_ready", {31'd0, start_ready}, 32'd0);
        step();
        chk("idle_start_ready", {31'd0, start_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat1, lat2;
        repeat (2) step();
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();

        run_op(3'b000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 33, 0);
        run_op(3'b011, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 33, 0);
        run_op(3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, 0);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, 0);
        run_op(3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33, 0);
        run_op(3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 33, 0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
        run_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, 0);
        run_op(3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 33, 0);
        run_op(3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33, 0);
        run_op(3'b100, 32'h80000000, 32'd2, 32'hC0000000, 33, 0);
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        run_op(3'b111, 32'd5, 32'd0, 32'h00000005, 1, 0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 33, 5);

        // reset in the middle of a divide
        funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (10) step();
        chk("mid_div_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_start_ready", {31'd0, start_ready}, 32'd1);
        rst = 1'b0;
        step();

        // 7*9 on the radix-16 and 16-bit instances together
        s1_valid = 1'b1; s2_valid = 1'b1;
        step();
        s1_valid = 1'b0; s2_valid = 1'b0;
        lat1 = -1; lat2 = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (r1_valid && lat1 < 0) lat1 = i;
            if (r2_valid && lat2 < 0) lat2 = i;
        end
        chk("step4_latency", 32'(lat1), 32'd9);
        chk("x16_latency", 32'(lat2), 32'd17);
        chk("step4_result", res1, model(32, 3'b000, 32'd7, 32'd9));
        chk("x16_result", {16'd0, res2}, 32'd63);
        r1_ready = 1'b1; r2_ready = 1'b1;
        step();
        r1_ready = 1'b0; r2_ready = 1'b0;
        chk("step4_idle", {31'd0, busy1}, 32'd0);
        chk("x16_idle", {31'd0, busy2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
